sha256_compress_iter: RTL and testbench

- Sequential, parametrised SHA-256 compression engine for the mining datapath.
- Iterates the 64 SHA-256 rounds over a 512-bit block, with UNROLL rounds per clock.
- Keeps its own 16-word message schedule and an internal K-constant ROM.
- Adds the chaining state back in (feed-forward) and returns the 256-bit digest under a start/done handshake.

---
 rtl/sha256_pkg.sv | 73 +++++++
 rtl/sha256_compress_iter_round.sv | 25 ++
 rtl/sha256_compress_iter.sv | 153 +++++++++++++++
 tb/tb_sha256_compress_iter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, the
// bitwise round/schedule functions, state types and the controller enum.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Working state a..h packed with a in the top word, matching hash_in/hash_out.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } hstate_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hstate_t H0 = '{
    a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
    e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_compress_iter_round.sv
// One combinational SHA-256 round: consumes a..h, K[t], W[t] and produces
// the next a..h. Chained UNROLL times inside the compression engine.
module sha256_round
  import sha256_pkg::*;
(
  input  hstate_t st_in,
  input  word_t   k,
  input  word_t   w,
  output hstate_t st_out
);

  word_t t1;
  word_t t2;

  // Round function; all sums wrap modulo 2^32 through the 32-bit word type.
  always_comb begin
    t1 = st_in.h + big_sigma1(st_in.e) + ch(st_in.e, st_in.f, st_in.g) + k + w;
    t2 = big_sigma0(st_in.a) + maj(st_in.a, st_in.b, st_in.c);
    st_out = '{
      a: t1 + t2, b: st_in.a, c: st_in.b, d: st_in.c,
      e: st_in.d + t1, f: st_in.e, g: st_in.f, h: st_in.g
    };
  end

endmodule

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression engine, UNROLL rounds per clock, with a
// 16-word rolling message schedule and feed-forward of the chaining state.
// Optional macro SHA256_DOUBLE_HASH_EN adds a dbl input that chains a second
// compression of the padded 256-bit digest (standard double SHA-256).
module sha256_compress_iter
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
`ifdef SHA256_DOUBLE_HASH_EN
  input  logic         dbl,
`endif
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  localparam int NCYC = 64 / UNROLL;
  localparam logic [5:0] CNT_LAST = 6'(NCYC - 1);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_compress_iter: UNROLL must be 1, 2, 4 or 8");
  end

  state_t     state;
  logic [5:0] cnt;
  hstate_t    work;
  hstate_t    iv;
  word_t      w   [0:15];
  word_t      ext [0:15+UNROLL];
  hstate_t    round_out;
  logic [255:0] digest;
`ifdef SHA256_DOUBLE_HASH_EN
  logic       dbl_r;
`endif

  function automatic logic [255:0] feed_forward(input hstate_t iv_s, input hstate_t wk);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = iv_s[32*i +: 32] + wk[32*i +: 32];
    return r;
  endfunction

  // Window W[t..t+15] extended by the UNROLL words W[t+16..] needed next edge.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int j = 16; j < 16 + UNROLL; j++)
      ext[j] = small_sigma1(ext[j-2]) + ext[j-7] + small_sigma0(ext[j-15]) + ext[j-16];
  end

  for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
    hstate_t    st_i;
    hstate_t    st_o;
    logic [5:0] kidx;
    assign kidx = cnt * 6'(UNROLL) + 6'(k);
    if (k == 0) begin : g_head
      assign st_i = work;
    end else begin : g_link
      assign st_i = g_rnd[k-1].st_o;
    end
    sha256_round u_round (
      .st_in (st_i),
      .k     (K[kidx]),
      .w     (ext[k]),
      .st_out(st_o)
    );
  end

  assign round_out = g_rnd[UNROLL-1].st_o;
  assign digest    = feed_forward(iv, work);
  assign busy      = ~ready;

  // Controller plus datapath registers: accept, iterate rounds, feed forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      iv       <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      hash_out <= '0;
      done     <= 1'b0;
      ready    <= 1'b1;
`ifdef SHA256_DOUBLE_HASH_EN
      dbl_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
            iv    <= hash_in;
            work  <= hash_in;
            cnt   <= '0;
            state <= ROUND;
            ready <= 1'b0;
`ifdef SHA256_DOUBLE_HASH_EN
            dbl_r <= dbl;
`endif
          end
        end
        ROUND: begin
          work <= round_out;
          for (int i = 0; i < 16; i++) w[i] <= ext[i+UNROLL];
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= FINAL;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        FINAL: begin
`ifdef SHA256_DOUBLE_HASH_EN
          if (dbl_r) begin
            // Second pass hashes the 32-byte digest as one padded block.
            for (int i = 0; i < 8; i++) w[i] <= digest[255-32*i -: 32];
            w[8] <= 32'h80000000;
            for (int i = 9; i < 15; i++) w[i] <= '0;
            w[15] <= 32'h00000100;
            iv    <= H0;
            work  <= H0;
            cnt   <= '0;
            dbl_r <= 1'b0;
            state <= ROUND;
          end else begin
            hash_out <= digest;
            done     <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end
`else
          hash_out <= digest;
          done     <= 1'b1;
          ready    <= 1'b1;
          state    <= IDLE;
`endif
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Self-checking bench for sha256_compress_iter: two instances (UNROLL=1 and
// UNROLL=4) checked against known digests and a FIPS-style software model.
module tb_sha256_compress_iter;

  localparam logic [255:0] IV0 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_DBL_EMPTY =
    256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         start1, start4;
  logic [511:0] blk;
  logic [255:0] hin;
  logic         ready1, busy1, done1;
  logic         ready4, busy4, done4;
  logic [255:0] hout1, hout4;
`ifdef SHA256_DOUBLE_HASH_EN
  logic         dbl;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sha256_compress_iter #(.UNROLL(1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef SHA256_DOUBLE_HASH_EN
    .dbl(dbl),
`endif
    .start(start1), .block_in(blk), .hash_in(hin),
    .ready(ready1), .busy(busy1), .done(done1), .hash_out(hout1)
  );

  sha256_compress_iter #(.UNROLL(4)) dut4 (
    .clk(clk), .rst(rst),
`ifdef SHA256_DOUBLE_HASH_EN
    .dbl(dbl),
`endif
    .start(start4), .block_in(blk), .hash_in(hin),
    .ready(ready4), .busy(busy4), .done(done4), .hash_out(hout4)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule and eight working variables.
  function automatic logic [255:0] ref_compress(input logic [255:0] hs, input logic [511:0] b);
    logic [31:0] wd [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) wd[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(wd[t-15], 7) ^ rotr(wd[t-15], 18) ^ (wd[t-15] >> 3);
      s1 = rotr(wd[t-2], 17) ^ rotr(wd[t-2], 19) ^ (wd[t-2] >> 10);
      wd[t] = wd[t-16] + s0 + wd[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hs[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wd[t];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hs[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom;
    return b;
  endfunction

  // Issue one request on the selected instance, optionally pulse start while
  // busy (noise_at > 0), and return the digest and edges from accept to done.
  task automatic run_block(input int sel, input logic [511:0] b, input logic [255:0] h,
                           input int noise_at, output logic [255:0] dig, output int lat);
    bit fin;
    @(negedge clk);
    blk = b;
    hin = h;
    if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    check_eq("ready_low_after_accept", 256'(sel == 1 ? ready1 : ready4), 256'(0));
    check_eq("busy_high_after_accept", 256'(sel == 1 ? busy1 : busy4), 256'(1));
    blk = rand_block();
    hin = ~h;
    lat = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == noise_at) begin
        blk = rand_block();
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
      end
      if (lat == noise_at + 3) begin
        start1 = 1'b0;
        start4 = 1'b0;
      end
      if ((sel == 1) ? done1 : done4) fin = 1'b1;
      if (lat > 400) begin
        check_eq("done_timeout", 256'(lat), 256'(0));
        fin = 1'b1;
      end
    end
    dig = (sel == 1) ? hout1 : hout4;
  endtask

  initial begin
    logic [255:0] dig, hexp;
    logic [511:0] b;
    int lat, sel, ncyc, gap;
    bit fin;

    rst = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    blk = '0;
    hin = '0;
`ifdef SHA256_DOUBLE_HASH_EN
    dbl = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready1", 256'(ready1), 256'(1));
    check_eq("rst_busy1", 256'(busy1), 256'(0));
    check_eq("rst_done1", 256'(done1), 256'(0));
    check_eq("rst_hout1", hout1, '0);
    check_eq("rst_ready4", 256'(ready4), 256'(1));
    check_eq("rst_hout4", hout4, '0);
    @(negedge clk);
    rst = 1'b0;

    // Known vector "abc" at one round per clock.
    run_block(1, BLK_ABC, IV0, -1, dig, lat);
    check_eq("abc_u1_digest", dig, DIG_ABC);
    check_eq("abc_u1_latency", 256'(lat), 256'(65));
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", 256'(done1), 256'(0));
    check_eq("hout_held", hout1, DIG_ABC);

    // Empty message at four rounds per clock.
    run_block(4, BLK_EMPTY, IV0, -1, dig, lat);
    check_eq("empty_u4_digest", dig, DIG_EMPTY);
    check_eq("empty_u4_latency", 256'(lat), 256'(17));

    // Random blocks and chaining values; the first two also see start while busy.
    for (int i = 0; i < 6; i++) begin
      sel  = (i % 2 == 0) ? 1 : 4;
      ncyc = 64 / sel;
      b = rand_block();
      for (int j = 0; j < 8; j++) hexp[32*j +: 32] = $urandom;
      run_block(sel, b, hexp, (i < 2) ? 5 : -1, dig, lat);
      check_eq("random_digest", dig, ref_compress(hexp, b));
      check_eq("random_latency", 256'(lat), 256'(ncyc + 1));
    end

    // All-ones chaining state stresses per-word wraparound in the feed-forward.
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? 1 : 4;
      b = rand_block();
      run_block(sel, b, {256{1'b1}}, -1, dig, lat);
      check_eq("wrap_digest", dig, ref_compress({256{1'b1}}, b));
    end

    // Back-to-back: a new request in the done cycle is accepted.
    run_block(1, BLK_ABC, IV0, -1, dig, lat);
    check_eq("b2b_first_digest", dig, DIG_ABC);
    blk = BLK_EMPTY;
    hin = IV0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    check_eq("b2b_done_dropped", 256'(done1), 256'(0));
    check_eq("b2b_accepted", 256'(ready1), 256'(0));
    gap = 1;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      gap++;
      if (done1) fin = 1'b1;
      if (gap > 400) begin
        check_eq("b2b_timeout", 256'(gap), 256'(0));
        fin = 1'b1;
      end
    end
    check_eq("b2b_gap", 256'(gap), 256'(66));
    check_eq("b2b_second_digest", hout1, DIG_EMPTY);

    // Asynchronous reset in the middle of a block, then a fresh request.
    @(negedge clk);
    blk = BLK_ABC;
    hin = IV0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_hout1", hout1, '0);
    check_eq("midrst_ready1", 256'(ready1), 256'(1));
    check_eq("midrst_busy1", 256'(busy1), 256'(0));
    check_eq("midrst_hout4", hout4, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_no_done", 256'(done1), 256'(0));
    run_block(1, BLK_ABC, IV0, -1, dig, lat);
    check_eq("after_rst_digest", dig, DIG_ABC);
    check_eq("after_rst_latency", 256'(lat), 256'(65));

`ifdef SHA256_DOUBLE_HASH_EN
    // Double hash of the empty message on both instances.
    for (int i = 0; i < 2; i++) begin
      sel  = (i == 0) ? 1 : 4;
      ncyc = 64 / sel;
      dbl = 1'b1;
      run_block(sel, BLK_EMPTY, IV0, -1, dig, lat);
      dbl = 1'b0;
      hexp = ref_compress(IV0, {ref_compress(IV0, BLK_EMPTY), 32'h80000000, 192'h0, 32'h00000100});
      check_eq("dbl_digest_const", dig, DIG_DBL_EMPTY);
      check_eq("dbl_digest_model", dig, hexp);
      check_eq("dbl_latency", 256'(lat), 256'(2 * (ncyc + 1)));
    end
    run_block(1, BLK_ABC, IV0, -1, dig, lat);
    check_eq("dbl0_digest", dig, DIG_ABC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
